// File: rtl/stride_window_sequencer.sv
// stride_window_sequencer: walks a 1-D input in windows of F elements advancing by S,
// issuing per-element read addresses under valid/ready and pulsing next_stride per window.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           pulse; latches filter_size/stride/input_len when idle
//   filter_size     window length F
//   stride          window advance S
//   input_len       input length L
//   addr_ready      read port accepts addr this cycle
//   addr_valid      addr is valid (SCAN)
//   addr            window base + elem_idx
//   elem_idx        position inside current window
//   next_stride     one-cycle pulse per completed window
//   busy            high in SCAN or STRIDE
//   done            one-cycle pulse at end of sequence
//   win_count       completed-window count, only with STRIDE_WINDOW_WINCNT_EN defined
module stride_window_sequencer #(
  parameter int WIDTH      = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      filter_size,
  input  logic [WIDTH-1:0]      stride,
  input  logic [ADDR_WIDTH-1:0] input_len,
  input  logic                  addr_ready,
  output logic                  addr_valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      elem_idx,
  output logic                  next_stride,
  output logic                  busy,
`ifdef STRIDE_WINDOW_WINCNT_EN
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] win_count
`else
  output logic                  done
`endif
);
  localparam int AW1 = ADDR_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, SCAN, STRIDE, DONE} state_t;
  state_t                state_q, state_d;
  logic [WIDTH-1:0]      f_q, f_d, s_q, s_d, idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] l_q, l_d, base_q, base_d;
  logic [AW1-1:0]        base_nx;
  logic                  cfg_bad, xfer, last_win;
`ifdef STRIDE_WINDOW_WINCNT_EN
  logic [ADDR_WIDTH-1:0] wc_q, wc_d;
  assign win_count = wc_q;
`endif
  // Extra bit keeps base+S and base+S+F from wrapping before the length compare
  assign base_nx  = {1'b0, base_q} + AW1'(s_q);
  assign last_win = (base_nx + AW1'(f_q)) > {1'b0, l_q};
  assign cfg_bad  = (filter_size == '0) || (stride == '0) || (ADDR_WIDTH'(filter_size) > input_len);
  assign xfer     = (state_q == SCAN) && addr_ready;
  assign addr_valid  = state_q == SCAN;
  assign next_stride = state_q == STRIDE;
  assign busy        = (state_q == SCAN) || (state_q == STRIDE);
  assign done        = state_q == DONE;
  assign addr        = base_q + ADDR_WIDTH'(idx_q);
  assign elem_idx    = idx_q;
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    s_d     = s_q;
    l_d     = l_q;
    base_d  = base_q;
    idx_d   = idx_q;
`ifdef STRIDE_WINDOW_WINCNT_EN
    wc_d    = wc_q;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        f_d     = filter_size;
        s_d     = stride;
        l_d     = input_len;
        base_d  = '0;
        idx_d   = '0;
        state_d = cfg_bad ? DONE : SCAN;
`ifdef STRIDE_WINDOW_WINCNT_EN
        wc_d    = '0;
`endif
      end
      SCAN: if (xfer) begin
        idx_d   = (idx_q == f_q - WIDTH'(1)) ? '0 : idx_q + WIDTH'(1);
        state_d = (idx_q == f_q - WIDTH'(1)) ? STRIDE : SCAN;
      end
      STRIDE: begin
        base_d  = last_win ? base_q : base_nx[ADDR_WIDTH-1:0];
        state_d = last_win ? DONE : SCAN;
`ifdef STRIDE_WINDOW_WINCNT_EN
        wc_d    = wc_q + ADDR_WIDTH'(1);
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      f_q     <= '0;
      s_q     <= '0;
      l_q     <= '0;
      base_q  <= '0;
      idx_q   <= '0;
`ifdef STRIDE_WINDOW_WINCNT_EN
      wc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      s_q     <= s_d;
      l_q     <= l_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
`ifdef STRIDE_WINDOW_WINCNT_EN
      wc_q    <= wc_d;
`endif
    end
  end
endmodule

// File: tb/tb_stride_window_sequencer.sv
// tb_stride_window_sequencer: scoreboard bench against a window-enumeration reference model
module tb_stride_window_sequencer;
  logic       clk = 0, rst = 1, start = 0, addr_ready = 0;
  logic [4:0] filter_size = 0, stride = 0;
  logic [7:0] input_len = 0;
  logic       addr_valid, next_stride, busy, done;
  logic [7:0] addr;
  logic [4:0] elem_idx;
`ifdef STRIDE_WINDOW_WINCNT_EN
  logic [7:0] win_count;
`endif
  typedef struct {int kind; int a; int i;} ev_t;
  ev_t q[$];
  int checks = 0, fails = 0;
  int mode = 0, rc = 0;
  bit have_prev = 0;
  logic [7:0] prev_addr;
  logic [4:0] prev_idx;
  stride_window_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .filter_size(filter_size), .stride(stride),
    .input_len(input_len), .addr_ready(addr_ready), .addr_valid(addr_valid), .addr(addr),
    .elem_idx(elem_idx), .next_stride(next_stride), .busy(busy),
`ifdef STRIDE_WINDOW_WINCNT_EN
    .done(done), .win_count(win_count)
`else
    .done(done)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: enumerate windows directly from F, S, L
  task automatic push_model(int f, int s, int l);
    int nw;
    ev_t e;
    nw = (f == 0 || s == 0 || f > l) ? 0 : (l - f) / s + 1;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < f; k++) begin
        e.kind = 0; e.a = w * s + k; e.i = k; q.push_back(e);
      end
      e.kind = 1; e.a = 0; e.i = 0; q.push_back(e);
    end
    e.kind = 2; e.a = nw; e.i = 0; q.push_back(e);
  endtask
  task automatic got(int kind);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", kind, -1);
      return;
    end
    e = q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == 0 && e.kind == 0) begin
      chk("addr", int'(addr), e.a);
      chk("elem_idx", int'(elem_idx), e.i);
    end
`ifdef STRIDE_WINDOW_WINCNT_EN
    if (kind == 2 && e.kind == 2) chk("win_count", int'(win_count), e.a);
`endif
  endtask
  always @(posedge clk) begin
    #1;
    rc++;
    addr_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (rc % 3 == 0) : 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (rst) have_prev = 0;
    else begin
      if (have_prev) begin
        chk("hold_valid", int'(addr_valid), 1);
        chk("hold_addr", int'(addr), int'(prev_addr));
        chk("hold_idx", int'(elem_idx), int'(prev_idx));
      end
      have_prev = addr_valid && !addr_ready;
      prev_addr = addr;
      prev_idx  = elem_idx;
      if (addr_valid && next_stride) chk("valid_and_stride", 1, 0);
      if (addr_valid && addr_ready) got(0);
      if (next_stride) got(1);
      if (done) got(2);
    end
  end
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    chk("idle_busy", int'(busy), 0);
    chk("idle_valid", int'(addr_valid), 0);
  endtask
  task automatic run(int f, int s, int l, int m, bit inj);
    bit ok;
    ok = f != 0 && s != 0 && f <= l;
    @(posedge clk);
    #1;
    mode = m;
    rc = 0;
    filter_size = 5'(f);
    stride = 5'(s);
    input_len = 8'(l);
    start = 1;
    push_model(f, s, l);
    @(posedge clk);
    #1;
    start = 0;
    chk("first_valid", int'(addr_valid), int'(ok));
    chk("first_done", int'(done), int'(!ok));
    chk("first_busy", int'(busy), int'(ok));
    if (inj) begin
      repeat (3) @(posedge clk);
      #1;
      filter_size = 5'd1; stride = 5'd1; input_len = 8'd20;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
    end
    drain();
  endtask
  initial begin
    #1;
    chk("rst_valid", int'(addr_valid), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_idx", int'(elem_idx), 0);
    chk("rst_stride", int'(next_stride), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    #22 rst = 0;
    run(3, 2, 8, 0, 0);
    run(3, 2, 8, 1, 0);
    run(5, 1, 5, 0, 0);
    run(2, 4, 6, 1, 0);
    run(0, 2, 8, 0, 0);
    run(3, 0, 8, 0, 0);
    run(6, 1, 5, 0, 0);
    run(1, 1, 1, 2, 0);
    run(3, 2, 8, 0, 1);
    for (int t = 0; t < 30; t++)
      run($urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 60), $urandom_range(0, 2), 0);
    @(posedge clk);
    #1;
    mode = 0;
    filter_size = 5'd3; stride = 5'd2; input_len = 8'd8;
    start = 1;
    push_model(3, 2, 8);
    @(posedge clk);
    #1;
    start = 0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("abort_valid", int'(addr_valid), 0);
    chk("abort_addr", int'(addr), 0);
    chk("abort_idx", int'(elem_idx), 0);
    chk("abort_stride", int'(next_stride), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
`ifdef STRIDE_WINDOW_WINCNT_EN
    chk("abort_wc", int'(win_count), 0);
`endif
    q.delete();
    @(posedge clk);
    #3;
    rst = 0;
    repeat (4) @(posedge clk);
    run(3, 2, 8, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/stride_window_sequencer.md
Name: stride_window_sequencer

Overview:
Initiator side of the next_stride interface. Walks a 1-D input of input_len elements in windows of filter_size elements, advancing by stride, and issues per-element read addresses under a valid/ready handshake. Emits one next_stride pulse per completed window, which drives the stride step counter's count_en, then signals done. Sits between the layer controller (start/config) and the input buffer read port.

Parameters:
WIDTH, 5, width of filter_size, stride, elem_idx
ADDR_WIDTH, 8, width of input_len and addr

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  pulse; latches config, begins sequence (ignored unless IDLE)
filter_size  input  WIDTH  window length F
stride  input  WIDTH  window advance S
input_len  input  ADDR_WIDTH  input length L
addr_ready  input  1  buffer accepts addr this cycle
addr_valid  output  1  addr is valid
addr  output  ADDR_WIDTH  base + elem_idx
elem_idx  output  WIDTH  position inside current window
next_stride  output  1  one-cycle pulse per completed window
busy  output  1  high in SCAN or STRIDE
done  output  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (async, any state): state=IDLE; addr_valid=0, addr=0, elem_idx=0, next_stride=0, busy=0, done=0; base=0; latched config=0.
- States: IDLE, SCAN, STRIDE, DONE. All outputs registered or decoded from state plus registers. No combinational path from addr_ready to addr_valid.
- IDLE: on start, latch F, S, L; base=0; elem_idx=0.
  - If F==0, S==0 or F>L: go to DONE. No addresses, no next_stride.
  - Otherwise go to SCAN. addr_valid rises the cycle after start is sampled.
- SCAN: addr_valid=1, addr=base+elem_idx.
  - Transfer occurs when addr_valid&&addr_ready.
  - On transfer with elem_idx==F-1: elem_idx=0, go to STRIDE.
  - On any other transfer: elem_idx+1.
  - With addr_ready low, addr and elem_idx hold stable.
- STRIDE: exactly one cycle. next_stride=1, addr_valid=0.
  - base_next=base+S, computed in ADDR_WIDTH+1 bits. No wrap.
  - If base_next+F <= L (ADDR_WIDTH+1 bit compare): base=base_next, go to SCAN.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Window count = floor((L-F)/S)+1. Number of next_stride pulses equals the window count. Addresses issued = window count × F.
- start while not IDLE: ignored. Config inputs are not sampled outside the start cycle.
- S>F is legal: elements are skipped. S<F is legal: elements are re-read.
- F==L: exactly one window.
- Reset mid-operation: immediate abort to reset values. No done, no further next_stride.

Optional Feature:
Macro STRIDE_WINDOW_WINCNT_EN.
- Defined: adds output win_count [ADDR_WIDTH-1:0].
  - Cleared on reset and on accepted start.
  - Increments in each STRIDE cycle.
  - Holds its final value after done until the next start.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- L=8, F=3, S=2, addr_ready=1, start at cycle T -> addr_valid from T+1. addr sequence 0,1,2 | 2,3,4 | 4,5,6. next_stride pulses after each group (3 total). done once. Back to IDLE. win_count=3 if enabled.
- Same config, addr_ready toggled 1,0,0,1,... -> addr/elem_idx held while ready=0. Identical address sequence and pulse count.
- L=5, F=5, S=1 -> addrs 0..4, one next_stride, done. L=6, F=2, S=4 -> addrs 0,1,4,5, two next_stride pulses.
- F=0 (also S=0; also F=6 with L=5) -> done one cycle after start. No addr_valid, no next_stride.
- start pulsed during SCAN with different config -> ignored, original sequence completes unchanged.
- rst asserted mid-SCAN of the second window -> all outputs 0 immediately, state IDLE, no done. A subsequent start runs a full clean sequence.
